// File: rtl/ioblock_bank.sv
// Bank of WIDTH I/O cells on one IOCLK: scan-loaded shadow config, per-pin tristate mux and optional registers.
// Optional IOBLOCK_BANK_SYNC2_EN turns the registered input path into a two-flop synchroniser.
module ioblock_bank #(
  parameter int WIDTH = 8
) (
  input  logic             IOCLK,
  input  logic             RST,
  inout  wire  [WIDTH-1:0] PIN,
  input  logic [WIDTH-1:0] OUT,
  input  logic [WIDTH-1:0] TS,
  output logic [WIDTH-1:0] IN,
  input  logic             CFG_SHIFT,
  input  logic             CFG_DIN,
  input  logic             CFG_UPDATE,
  output logic             CFG_DOUT
);

  localparam int CFG_BITS = 4;
  localparam int N        = CFG_BITS * WIDTH;

  logic [N-1:0]     r_chain;
  logic [N-1:0]     r_active;
  logic [WIDTH-1:0] r_out_p1;
  logic [WIDTH-1:0] r_ts_p1;
  logic [WIDTH-1:0] r_in_p1;
  logic [WIDTH-1:0] w_in_reg;
  logic [WIDTH-1:0] w_o_eff;
  logic [WIDTH-1:0] w_t_eff;
  logic [WIDTH-1:0] w_drive;

  function automatic logic drive_en(input logic [1:0] tsmux, input logic t);
    logic en;
    case (tsmux)
      2'b00:   en = 1'b0;
      2'b01:   en = t;
      2'b10:   en = 1'b1;
      default: en = ~t;
    endcase
    return en;
  endfunction

  // Scan chain and shadow commit; a shift in the same cycle wins over an update.
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      r_chain  <= '0;
      r_active <= '0;
    end else if (CFG_SHIFT) begin
      r_chain  <= {r_chain[N-2:0], CFG_DIN};
    end else if (CFG_UPDATE) begin
      r_active <= r_chain;
    end
  end

  // Stage p1: I/O registers sample every cycle whatever the mode bits say.
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      r_out_p1 <= '0;
      r_ts_p1  <= '0;
      r_in_p1  <= '0;
    end else begin
      r_out_p1 <= OUT;
      r_ts_p1  <= TS;
      r_in_p1  <= PIN;
    end
  end

`ifdef IOBLOCK_BANK_SYNC2_EN
  logic [WIDTH-1:0] r_in_p2;

  // Stage p2: second synchroniser flop.
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      r_in_p2 <= '0;
    end else begin
      r_in_p2 <= r_in_p1;
    end
  end

  assign w_in_reg = r_in_p2;
`else
  assign w_in_reg = r_in_p1;
`endif

  genvar p;
  for (p = 0; p < WIDTH; p++) begin : g_pin
    logic [CFG_BITS-1:0] w_cfg;

    assign w_cfg      = r_active[CFG_BITS*p +: CFG_BITS];
    assign w_o_eff[p] = w_cfg[3] ? r_out_p1[p] : OUT[p];
    assign w_t_eff[p] = w_cfg[3] ? r_ts_p1[p]  : TS[p];
    assign w_drive[p] = drive_en(w_cfg[1:0], w_t_eff[p]);
    assign PIN[p]     = w_drive[p] ? w_o_eff[p] : 1'bz;
    assign IN[p]      = w_cfg[2] ? w_in_reg[p] : PIN[p];
  end

  assign CFG_DOUT = r_chain[N-1];

endmodule

// File: tb/tb_ioblock_bank.sv
// Bench for ioblock_bank: two copies of the bank, one with pulled-up pins and one with pulled-down pins,
// so a floating pin reads differently in each and can be told apart from a driven one.
module tb_ioblock_bank;

  localparam int WIDTH = 8;
  localparam int N     = 4 * WIDTH;
`ifdef IOBLOCK_BANK_SYNC2_EN
  localparam int IN_LAT = 2;
`else
  localparam int IN_LAT = 1;
`endif

  typedef struct packed {
    logic       outreg;
    logic       inreg;
    logic [1:0] tsmux;
  } cfg_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] out_v;
  logic [WIDTH-1:0] ts_v;
  logic             cfg_shift;
  logic             cfg_din;
  logic             cfg_update;
  logic             ext_en;
  logic [WIDTH-1:0] ext_val;
  wire  [WIDTH-1:0] pin_a;
  wire  [WIDTH-1:0] pin_b;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             dout_a;
  logic             dout_b;

  int n_cmp;
  int n_mis;

  // Reference model state: pin codes are 0/1 for a driven level, 2 for floating.
  bit         m_chain[$];
  cfg_t       m_cfg [WIDTH];
  logic [WIDTH-1:0] m_oreg;
  logic [WIDTH-1:0] m_treg;
  logic [1:0] m_in1 [WIDTH];
  logic [1:0] m_in2 [WIDTH];

  always #5 clk = ~clk;

  pullup   (pin_a);
  pulldown (pin_b);
  assign pin_a = ext_en ? ext_val : {WIDTH{1'bz}};
  assign pin_b = ext_en ? ext_val : {WIDTH{1'bz}};

  ioblock_bank #(.WIDTH(WIDTH)) u_a (
    .IOCLK(clk), .RST(rst), .PIN(pin_a), .OUT(out_v), .TS(ts_v), .IN(in_a),
    .CFG_SHIFT(cfg_shift), .CFG_DIN(cfg_din), .CFG_UPDATE(cfg_update), .CFG_DOUT(dout_a)
  );

  ioblock_bank #(.WIDTH(WIDTH)) u_b (
    .IOCLK(clk), .RST(rst), .PIN(pin_b), .OUT(out_v), .TS(ts_v), .IN(in_b),
    .CFG_SHIFT(cfg_shift), .CFG_DIN(cfg_din), .CFG_UPDATE(cfg_update), .CFG_DOUT(dout_b)
  );

  function automatic logic [2*WIDTH-1:0] codes(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] r;
    for (int p = 0; p < WIDTH; p++) begin
      if (a[p] == b[p]) r[2*p +: 2] = {1'b0, a[p]};
      else              r[2*p +: 2] = a[p] ? 2'd2 : 2'd3;
    end
    return r;
  endfunction

  task automatic reset_model();
    m_chain.delete();
    repeat (N) m_chain.push_back(1'b0);
    for (int p = 0; p < WIDTH; p++) begin
      m_cfg[p] = '0;
      m_in1[p] = 2'd0;
      m_in2[p] = 2'd0;
    end
    m_oreg = '0;
    m_treg = '0;
  endtask

  // Chain bit k sits at queue position N-1-k (oldest shifted bit is the MSB).
  function automatic cfg_t cfg_of(input int p);
    cfg_t c;
    c = {m_chain[N-1-(4*p+3)], m_chain[N-1-(4*p+2)], m_chain[N-1-(4*p+1)], m_chain[N-1-4*p]};
    return c;
  endfunction

  function automatic logic [1:0] exp_pin(input int p);
    cfg_t c;
    logic o, t, d;
    c = m_cfg[p];
    o = c.outreg ? m_oreg[p] : out_v[p];
    t = c.outreg ? m_treg[p] : ts_v[p];
    case (c.tsmux)
      2'd0:    d = 1'b0;
      2'd1:    d = t;
      2'd2:    d = 1'b1;
      default: d = !t;
    endcase
    if (d)      return {1'b0, o};
    if (ext_en) return {1'b0, ext_val[p]};
    return 2'd2;
  endfunction

  function automatic logic [1:0] exp_in(input int p);
    if (!m_cfg[p].inreg) return exp_pin(p);
    return (IN_LAT == 2) ? m_in2[p] : m_in1[p];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [1:0] pre [WIDTH];
    for (int p = 0; p < WIDTH; p++) pre[p] = exp_pin(p);
    @(posedge clk);
    #1;
    if (rst) begin
      reset_model();
    end else begin
      for (int p = 0; p < WIDTH; p++) begin
        m_in2[p] = m_in1[p];
        m_in1[p] = pre[p];
      end
      m_oreg = out_v;
      m_treg = ts_v;
      if (cfg_shift) begin
        m_chain.push_back(cfg_din);
        void'(m_chain.pop_front());
      end else if (cfg_update) begin
        for (int p = 0; p < WIDTH; p++) m_cfg[p] = cfg_of(p);
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [2*WIDTH-1:0] ep, ei;
    #1;
    for (int p = 0; p < WIDTH; p++) begin
      ep[2*p +: 2] = exp_pin(p);
      ei[2*p +: 2] = exp_in(p);
    end
    chk({tag, "_pin"},  64'(codes(pin_a, pin_b)), 64'(ep));
    chk({tag, "_in"},   64'(codes(in_a, in_b)),   64'(ei));
    chk({tag, "_dout"}, 64'({dout_a, dout_b}),    64'({2{m_chain[0]}}));
  endtask

  task automatic load(input logic [N-1:0] w);
    for (int i = N - 1; i >= 0; i--) begin
      cfg_shift = 1'b1;
      cfg_din   = w[i];
      out_v     = WIDTH'($urandom);
      ts_v      = WIDTH'($urandom);
      check_all("load");
      tick();
    end
    cfg_shift = 1'b0;
    check_all("load_done");
  endtask

  task automatic commit();
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
  endtask

  initial begin
    logic [N-1:0]       pat;
    logic [2*WIDTH-1:0] tmp;
    logic [3:0]         tri_exp [4];
    int                 lat;

    n_cmp = 0;
    n_mis = 0;
    tri_exp = '{4'b0110, 4'b0101, 4'b1010, 4'b1001};

    rst        = 1'b1;
    cfg_shift  = 1'b0;
    cfg_din    = 1'b0;
    cfg_update = 1'b0;
    ext_en     = 1'b0;
    ext_val    = '0;
    out_v      = WIDTH'($urandom);
    ts_v       = WIDTH'($urandom);
    reset_model();

    check_all("reset");
    chk("reset_pins_z", 64'(codes(pin_a, pin_b)), 64'({WIDTH{2'b10}}));
    ext_en  = 1'b1;
    ext_val = 8'hA5;
    check_all("reset_ext");
    chk("reset_in_a5", 64'({in_a, in_b}), 64'({8'hA5, 8'hA5}));
    ext_val = 8'h5A;
    check_all("reset_ext2");
    chk("reset_in_5a", 64'({in_a, in_b}), 64'({8'h5A, 8'h5A}));
    tick();
    ext_en = 1'b0;
    rst    = 1'b0;
    check_all("reset_release");

    pat = 32'hDEADBEEF;
    for (int k = 0; k < 2 * N; k++) begin
      cfg_shift = 1'b1;
      cfg_din   = (k < N) ? pat[N-1-k] : 1'b0;
      out_v     = WIDTH'($urandom);
      ts_v      = WIDTH'($urandom);
      check_all("readback_shift");
      tick();
      if (k >= N - 1 && k <= 2 * N - 2)
        chk("readback_dout", 64'(dout_a), 64'(pat[2*N-2-k]));
    end
    cfg_shift = 1'b0;

    load(32'h0000_0002);
    tmp = codes(pin_a, pin_b);
    chk("shadow_pin0_z", 64'(tmp[1:0]), 64'(2'd2));
    commit();
    check_all("update_edge");
    tmp = codes(pin_a, pin_b);
    chk("update_pin0_out", 64'(tmp[1:0]), 64'({1'b0, out_v[0]}));
    out_v[0] = ~out_v[0];
    check_all("update_follow");
    cfg_shift  = 1'b1;
    cfg_update = 1'b1;
    cfg_din    = 1'b1;
    tick();
    cfg_shift  = 1'b0;
    cfg_update = 1'b0;
    check_all("collide");
    tmp = codes(pin_a, pin_b);
    chk("collide_pin0_kept", 64'(tmp[1:0]), 64'({1'b0, out_v[0]}));

    load(32'h0000_0031);
    commit();
    out_v = 8'h03;
    for (int t = 0; t < 4; t++) begin
      ts_v = WIDTH'(t);
      check_all("ts_sweep");
      tmp = codes(pin_a, pin_b);
      chk("ts_sweep_pins", 64'(tmp[3:0]), 64'(tri_exp[t]));
    end

    load(32'h0000_0E00);
    out_v = '0;
    ts_v  = '0;
    commit();
    repeat (3) begin
      check_all("reg_settle");
      tick();
    end
    out_v[2] = 1'b1;
    check_all("reg_step");
    tmp = codes(pin_a, pin_b);
    chk("reg_pin_hold", 64'(tmp[5:4]), 64'(2'd0));
    tick();
    check_all("reg_edge1");
    tmp = codes(pin_a, pin_b);
    chk("reg_pin_rise", 64'(tmp[5:4]), 64'(2'd1));
    lat = 1;
    while (in_a[2] !== 1'b1 && lat < 6) begin
      tick();
      check_all("reg_in_wait");
      lat++;
    end
    chk("reg_in_latency", 64'(lat), 64'(1 + IN_LAT));

    load(32'h2222_2222);
    commit();
    out_v = WIDTH'($urandom);
    check_all("pre_rst_drive");
    for (int i = 0; i < 10; i++) begin
      cfg_shift = 1'b1;
      cfg_din   = 1'($urandom);
      out_v     = WIDTH'($urandom);
      check_all("pre_rst_shift");
      tick();
    end
    #2;
    rst = 1'b1;
    reset_model();
    check_all("async_rst");
    chk("async_rst_pins_z", 64'(codes(pin_a, pin_b)), 64'({WIDTH{2'b10}}));
    tick();
    rst       = 1'b0;
    cfg_shift = 1'b1;
    cfg_din   = 1'b1;
    for (int i = 0; i < N; i++) begin
      check_all("rst_shiftout");
      chk("rst_shiftout_zero", 64'(dout_a), 64'(0));
      tick();
    end
    cfg_shift = 1'b0;
    check_all("rst_shiftout_end");

    for (int r = 0; r < 6; r++) begin
      load(N'($urandom));
      cfg_update = 1'b1;
      cfg_shift  = ($urandom_range(0, 3) == 0);
      cfg_din    = 1'($urandom);
      check_all("rand_commit");
      tick();
      cfg_update = 1'b0;
      cfg_shift  = 1'b0;
      for (int c = 0; c < 12; c++) begin
        out_v = WIDTH'($urandom);
        ts_v  = WIDTH'($urandom);
        check_all("rand_run");
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
